// File: rtl/ifmap_pkg.sv
// Shared definitions for the ifmap scratchpad receiver: default sizes, the
// FSM state encoding and the width of the window-size (need) arithmetic.
package ifmap_pkg;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 32;
    localparam int NEED_W = 10;
    localparam int CFG_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // cfg_fw * cfg_ic; 31*31 = 961 still fits in NEED_W bits
    function automatic logic [NEED_W-1:0] calc_need(input logic [CFG_W-1:0] fw,
                                                    input logic [CFG_W-1:0] ic);
        return NEED_W'(fw) * NEED_W'(ic);
    endfunction

endpackage

// File: rtl/ifmap_spad_rx_spad_ram.sv
// DEPTH x DATA_W scratchpad, one write and one synchronous read port.
// IFMAP_RX_ZERO_SKIP_EN adds a zero flag registered alongside the read word.
module spad_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rzero_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

`ifdef IFMAP_RX_ZERO_SKIP_EN
    logic rzero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rzero_q <= 1'b0;
        end else if (re_i) begin
            rzero_q <= (mem_q[raddr_i] == '0);
        end
    end

    assign rzero_o = rzero_q;
`else
    assign rzero_o = 1'b0;
`endif

endmodule

// File: rtl/ifmap_spad_rx.sv
// Ifmap scratchpad receiver: loads a sliding filter window from the diagonal
// bus and replays it to the MAC. Zero-skip hint enabled by IFMAP_RX_ZERO_SKIP_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no session; waits for en with a legal cfg_fw*cfg_ic
// ST_LOAD  | accepting din_vld words until count reaches need
// ST_READY | full window resident; rd_req streams words out
// ST_DONE  | window fully read; slide advances, rd_req replays
module ifmap_spad_rx #(
    parameter int DATA_W = ifmap_pkg::DATA_W,
    parameter int DEPTH  = ifmap_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [4:0]        cfg_ic,
    input  logic [4:0]        cfg_fw,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    input  logic              rd_req,
    input  logic              slide,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic              rd_last,
    output logic              rd_zero,
    output logic              ready,
    output logic              cfg_err,
    output logic              ovf
);

    import ifmap_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [NEED_W-1:0] need_q, need_d;
    logic [NEED_W-1:0] count_q, count_d;
    logic [NEED_W-1:0] rd_idx_q, rd_idx_d;
    logic [4:0]        ic_q, ic_d;
    logic [AW-1:0]     head_q, head_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_last_q, rd_last_d;
    logic              cfg_err_q, cfg_err_d;
    logic              ovf_q, ovf_d;

    logic              we;
    logic              re;
    logic              do_read;
    logic              is_last;
    logic [AW-1:0]     raddr;
    logic [NEED_W-1:0] need_calc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            need_q    <= '0;
            count_q   <= '0;
            rd_idx_q  <= '0;
            ic_q      <= '0;
            head_q    <= '0;
            wr_ptr_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            cfg_err_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            need_q    <= need_d;
            count_q   <= count_d;
            rd_idx_q  <= rd_idx_d;
            ic_q      <= ic_d;
            head_q    <= head_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_vld_q  <= rd_vld_d;
            rd_last_q <= rd_last_d;
            cfg_err_q <= cfg_err_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        need_d    = need_q;
        count_d   = count_q;
        rd_idx_d  = rd_idx_q;
        ic_d      = ic_q;
        head_d    = head_q;
        wr_ptr_d  = wr_ptr_q;
        rd_vld_d  = 1'b0;
        rd_last_d = 1'b0;
        cfg_err_d = cfg_err_q;
        ovf_d     = ovf_q | (din_vld & ~(en & (state_q == ST_LOAD)));
        we        = 1'b0;
        re        = 1'b0;
        do_read   = 1'b0;
        need_calc = calc_need(cfg_fw, cfg_ic);
        // rd_idx is always below need <= DEPTH, so its low bits are the offset
        raddr     = head_q + rd_idx_q[AW-1:0];
        is_last   = (rd_idx_q == need_q - NEED_W'(1));

        if (!en) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            head_d   = '0;
            wr_ptr_d = '0;
            rd_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (need_calc == '0 || need_calc > NEED_W'(DEPTH)) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        need_d  = need_calc;
                        ic_d    = cfg_ic;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (din_vld) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + NEED_W'(1);
                        if (count_q + NEED_W'(1) == need_q) begin
                            state_d = ST_READY;
                        end
                    end
                end
                ST_READY: begin
                    do_read = rd_req;
                end
                ST_DONE: begin
                    // slide has priority; a lone rd_req restarts from rd_idx 0
                    if (slide) begin
                        head_d  = head_q + AW'(ic_q);
                        count_d = count_q - NEED_W'(ic_q);
                        state_d = ST_LOAD;
                    end else begin
                        do_read = rd_req;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_read) begin
                re        = 1'b1;
                rd_vld_d  = 1'b1;
                rd_last_d = is_last;
                if (is_last) begin
                    rd_idx_d = '0;
                    state_d  = ST_DONE;
                end else begin
                    rd_idx_d = rd_idx_q + NEED_W'(1);
                    state_d  = ST_READY;
                end
            end
        end
    end

    spad_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_spad_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (wr_ptr_q),
        .wdata_i (din),
        .re_i    (re),
        .raddr_i (raddr),
        .rdata_o (rd_data),
        .rzero_o (rd_zero)
    );

    assign rd_vld  = rd_vld_q;
    assign rd_last = rd_last_q;
    assign ready   = (state_q == ST_READY);
    assign cfg_err = cfg_err_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_ifmap_spad_rx.sv
// Scoreboard bench for ifmap_spad_rx with DEPTH=8 so windows wrap quickly.
module tb_ifmap_spad_rx;

    localparam int DW  = 16;
    localparam int DEP = 8;
`ifdef IFMAP_RX_ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [4:0]    cfg_ic;
    logic [4:0]    cfg_fw;
    logic [DW-1:0] din;
    logic          din_vld;
    logic          rd_req;
    logic          slide;
    logic [DW-1:0] rd_data;
    logic          rd_vld;
    logic          rd_last;
    logic          rd_zero;
    logic          ready;
    logic          cfg_err;
    logic          ovf;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ifmap_spad_rx #(.DATA_W(DW), .DEPTH(DEP)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .cfg_ic  (cfg_ic),
        .cfg_fw  (cfg_fw),
        .din     (din),
        .din_vld (din_vld),
        .rd_req  (rd_req),
        .slide   (slide),
        .rd_data (rd_data),
        .rd_vld  (rd_vld),
        .rd_last (rd_last),
        .rd_zero (rd_zero),
        .ready   (ready),
        .cfg_err (cfg_err),
        .ovf     (ovf)
    );

    // Monitor: every rd_vld must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rd_vld !== 1'b0) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_rd_vld: rd_data=0x%0h with no read outstanding", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.data || rd_last !== e.last || rd_zero !== (ZS && e.data == '0)) begin
                    miscompares++;
                    $display("FAIL rd_word: got data=0x%0h last=%0b zero=%0b, expected data=0x%0h last=%0b zero=%0b",
                             rd_data, rd_last, rd_zero, e.data, e.last, (ZS && e.data == '0));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [4:0] fw, input logic [4:0] ic);
        cfg_fw = fw;
        cfg_ic = ic;
        en     = 1'b1;
        cyc();
    endtask

    task automatic load_word(input logic [DW-1:0] d, input logic exp_rdy);
        din     = d;
        din_vld = 1'b1;
        cyc();
        din_vld = 1'b0;
        chk("ready_after_load", 32'(ready), 32'(exp_rdy));
    endtask

    task automatic read_word(input logic [DW-1:0] d, input logic last);
        exp_t e;
        e.data = d;
        e.last = last;
        sb.push_back(e);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_data"}, 32'(rd_data), 0);
        chk({tag, "_rd_vld"},  32'(rd_vld),  0);
        chk({tag, "_rd_last"}, 32'(rd_last), 0);
        chk({tag, "_rd_zero"}, 32'(rd_zero), 0);
        chk({tag, "_ready"},   32'(ready),   0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 0);
        chk({tag, "_ovf"},     32'(ovf),     0);
    endtask

    logic [DW-1:0] bw [8];

    initial begin
        rst = 1'b1; en = 1'b0; cfg_ic = '0; cfg_fw = '0;
        din = '0; din_vld = 1'b0; rd_req = 1'b0; slide = 1'b0;
        bw[0] = 16'd0; bw[1] = 16'd5;   bw[2] = 16'd9; bw[3] = 16'd0;
        bw[4] = 16'd100; bw[5] = 16'd7; bw[6] = 16'd0; bw[7] = 16'd255;

        #12;
        chk_all_zero("reset");
        @(negedge clk) rst = 1'b0;
        cyc();

        // fw=3, ic=2: load 1..6, read back 1..6
        start(5'd3, 5'd2);
        for (int i = 1; i <= 6; i++) load_word(DW'(i), i == 6);
        for (int i = 1; i <= 6; i++) read_word(DW'(i), i == 6);
        chk("ready_in_done", 32'(ready), 0);

        // slides: after k slides the window is 2k+1 .. 2k+6 (head wraps at 8)
        for (int k = 1; k <= 3; k++) begin
            slide = 1'b1;
            cyc();
            slide = 1'b0;
            chk("ready_after_slide", 32'(ready), 0);
            load_word(DW'(2*k + 5), 1'b0);
            load_word(DW'(2*k + 6), 1'b1);
            for (int j = 0; j < 6; j++) read_word(DW'(2*k + 1 + j), j == 5);
        end

        // replay from DONE without slide
        for (int j = 0; j < 6; j++) read_word(DW'(7 + j), j == 5);

        // slide and rd_req together: slide wins, no read
        slide = 1'b1; rd_req = 1'b1;
        cyc();
        slide = 1'b0; rd_req = 1'b0;
        chk("ready_slide_wins", 32'(ready), 0);
        load_word(DW'(13), 1'b0);
        load_word(DW'(14), 1'b1);

        // din_vld while READY is dropped
        chk("ovf_clear", 32'(ovf), 0);
        din = 16'hBEEF; din_vld = 1'b1;
        cyc();
        din_vld = 1'b0;
        chk("ovf_set", 32'(ovf), 1);
        chk("ready_kept", 32'(ready), 1);
        for (int j = 0; j < 6; j++) read_word(DW'(9 + j), j == 5);

        // en dropped mid-load, then a fresh load from count 0
        en = 1'b0;
        cyc();
        chk("ready_en_low", 32'(ready), 0);
        start(5'd3, 5'd2);
        for (int i = 0; i < 3; i++) load_word(DW'(21 + i), 1'b0);
        en = 1'b0;
        cyc();
        start(5'd3, 5'd2);
        for (int i = 0; i < 6; i++) load_word(DW'(31 + i), i == 5);
        for (int i = 0; i < 6; i++) read_word(DW'(31 + i), i == 5);
        chk("ovf_sticky", 32'(ovf), 1);
        chk("cfg_err_clear", 32'(cfg_err), 0);

        // need == DEPTH boundary, with zero words
        en = 1'b0;
        cyc();
        start(5'd4, 5'd2);
        for (int i = 0; i < 8; i++) load_word(bw[i], i == 7);
        for (int i = 0; i < 8; i++) read_word(bw[i], i == 7);

        // need 36 > DEPTH: cfg_err, stays IDLE
        en = 1'b0;
        cyc();
        start(5'd6, 5'd6);
        cyc();
        chk("cfg_err_set", 32'(cfg_err), 1);
        chk("ready_cfg_err", 32'(ready), 0);
        load_word(DW'(1), 1'b0);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk("no_rd_vld_idle", 32'(rd_vld), 0);

        // rst mid-READY clears everything asynchronously
        en = 1'b0;
        cyc();
        start(5'd3, 5'd2);
        for (int i = 0; i < 6; i++) load_word(DW'(41 + i), i == 5);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk("pre_rst_rd_vld", 32'(rd_vld), 1);
        chk("pre_rst_rd_data", 32'(rd_data), 41);
        #1 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        en = 1'b0;
        @(negedge clk) rst = 1'b0;
        cyc();

        // first session after reset behaves as from power-up
        start(5'd3, 5'd2);
        for (int i = 1; i <= 6; i++) load_word(DW'(50 + i), i == 6);
        for (int i = 1; i <= 6; i++) read_word(DW'(50 + i), i == 6);

        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ifmap_spad_rx.md
IFMAP_SPAD_RX -- requirements
Module: ifmap_spad_rx

Interface
REQ-001 Parameter DATA_W, default 16: ifmap word width, matching the diagonal-bus width.
REQ-002 Parameter DEPTH, default 32: scratchpad entries; SHALL be a power of 2.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 en  in  1  load-session enable, same meaning as the ifmap bank enable; low means abort/idle.
REQ-006 cfg_ic  in  5  channels per PE (ic).
REQ-007 cfg_fw  in  5  filter width (filter_width).
REQ-008 din  in  DATA_W  diagonal-bus ifmap word.
REQ-009 din_vld  in  1  din is addressed to this PE this cycle.
REQ-010 rd_req  in  1  MAC requests the next window word.
REQ-011 slide  in  1  advance window by one column; discard the oldest cfg_ic words.
REQ-012 rd_data  out  DATA_W  read word, registered.
REQ-013 rd_vld  out  1  rd_data valid.
REQ-014 rd_last  out  1  rd_data is the final word of the window.
REQ-015 rd_zero  out  1  rd_data == 0 (zero-skip hint).
REQ-016 ready  out  1  full window resident (state READY).
REQ-017 cfg_err  out  1  sticky; illegal configuration.
REQ-018 ovf  out  1  sticky; din_vld dropped.

Function
REQ-019 States: IDLE, LOAD, READY, DONE; state and all counters SHALL be registered.
REQ-020 need = cfg_fw*cfg_ic, computed 10-bit unsigned and sampled on the IDLE->LOAD transition.
REQ-021 IDLE->LOAD when en=1 and 0<need<=DEPTH; if need==0 or need>DEPTH, set cfg_err and stay in IDLE.
REQ-022 LOAD: each din_vld writes din at wr_ptr, wr_ptr+1 mod DEPTH, count+1; when count reaches need, move to READY on the same edge.
REQ-023 READY: each rd_req outputs entry (head+rd_idx) mod DEPTH one cycle later with rd_vld=1, rd_idx+1; rd_last=1 on rd_idx==need-1, then move to DONE and reset rd_idx to 0.
REQ-024 DONE: slide=1 moves head+cfg_ic mod DEPTH, count-cfg_ic, then LOAD to accept exactly cfg_ic new words.
REQ-025 Reads SHALL be restartable: in DONE, rd_req without slide returns to READY and replays the window from rd_idx 0 with the same latency.
REQ-026 din_vld outside LOAD is dropped and sets ovf; rd_req outside READY/DONE is ignored with rd_vld=0; slide outside DONE is ignored.
REQ-027 slide and rd_req together in DONE: slide wins; rd_req is ignored.
REQ-028 en=0 in any state returns to IDLE next edge; count, head, wr_ptr, rd_idx cleared; sticky flags held.
REQ-029 Pointers wrap modulo DEPTH with no bubble; throughput is one write or one read per cycle.

Reset
REQ-030 On rst: state IDLE, pointers/count/rd_idx 0, rd_data 0, rd_vld 0, rd_last 0, rd_zero 0, ready 0, cfg_err 0, ovf 0; scratchpad contents are not reset.
REQ-031 rst asserted mid-session aborts immediately; the first session after deassertion behaves as from power-up.

Configuration
REQ-032 Macro IFMAP_RX_ZERO_SKIP_EN defined: rd_zero = (rd_data==0) and registered with rd_data; undefined: rd_zero tied 0 and its logic is omitted.

Structure
REQ-033 The shared package ifmap_pkg holds DATA_W, DEPTH, the state encoding, and the 10-bit need width.
REQ-034 One sub-module, spad_ram (DEPTH x DATA_W, 1W1R, sync read), holds the storage; FSM and pointers stay in ifmap_spad_rx.

Verification
REQ-035 fw=3, ic=2, 6 din_vld words 1..6 -> ready after 6th; 6 rd_req -> rd_data 1..6 at latency 1, rd_last with 6.
REQ-036 After REQ-035, slide, load 7,8 -> window reads 3,4,5,6,7,8; repeat slides across wrap with DEPTH=8 and verify order.
REQ-037 fw=6, ic=6 (need 36 > 32) -> cfg_err=1, state stays IDLE, ready=0.
REQ-038 din_vld during READY -> ovf=1, window data unchanged; slide with rd_req in DONE -> slide taken, no rd_vld.
REQ-039 en dropped after 3 of 6 words, then re-raised -> fresh load from count 0; rst mid-READY -> all outputs 0 asynchronously.
REQ-040 With IFMAP_RX_ZERO_SKIP_EN, load 0,5 -> rd_zero 1,0; without the macro -> rd_zero stays 0.
